// File: rtl/sync_filter_signals.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_signals
// Description : Multi-channel input conditioner for the video inputs.
//               Each asynchronous bit passes through a SYNC_STAGES-deep
//               synchronizer, a persistence-counter glitch filter and an
//               edge detector producing registered rise/fall strobes.
//               Optional feature macro: SYNC_GLITCH_COUNT_EN adds a
//               saturating 16-bit count of cycles with rejected glitches
//               (ports glitch_clr / glitch_count).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_signals #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef SYNC_GLITCH_COUNT_EN
  ,
  input  logic             glitch_clr,
  output logic [15:0]      glitch_count
`endif
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

`ifdef SYNC_GLITCH_COUNT_EN
  logic [WIDTH-1:0] w_reject;
  logic [15:0]      r_glitch_count;
`endif

  // Synchronizer shift register: stage 0 samples the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_VALUE;
    end else begin
      r_sync[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CW-1:0] r_cnt;
      logic          r_filt;
      logic          r_rise;
      logic          r_fall;

      // Persistence filter: accept a new level only after FILTER_CYCLES
      // consecutive disagreeing samples; strobe the direction on acceptance
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt  <= '0;
          r_filt <= RESET_VALUE[i];
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (sync_out[i] == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            r_cnt  <= '0;
            r_filt <= sync_out[i];
            r_rise <= sync_out[i];
            r_fall <= ~sync_out[i];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign filt_out[i]   = r_filt;
      assign rise_pulse[i] = r_rise;
      assign fall_pulse[i] = r_fall;

`ifdef SYNC_GLITCH_COUNT_EN
      // A glitch is rejected when a running count collapses back to agreement
      assign w_reject[i] = (r_cnt != '0) && (sync_out[i] == r_filt);
`endif
    end
  endgenerate

`ifdef SYNC_GLITCH_COUNT_EN
  // Saturating count of cycles containing at least one rejected glitch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_count <= '0;
    end else if (glitch_clr) begin
      r_glitch_count <= '0;
    end else if ((|w_reject) && (r_glitch_count != 16'hFFFF)) begin
      r_glitch_count <= r_glitch_count + 16'd1;
    end
  end

  assign glitch_count = r_glitch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_signals.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_filter_signals
// Description : Directed self-checking bench for sync_filter_signals.
//               Main instance: WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3.
//               Corner instance: WIDTH=1, SYNC_STAGES=3, FILTER_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_filter_signals;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] async_in;
  logic [3:0] sync_out, filt_out, rise_pulse, fall_pulse;
  logic [0:0] async_in6;
  logic [0:0] sync_out6, filt_out6, rise_pulse6, fall_pulse6;
`ifdef SYNC_GLITCH_COUNT_EN
  logic        glitch_clr, glitch_clr6;
  logic [15:0] glitch_count, glitch_count6;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  sync_filter_signals #(
    .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .async_in(async_in),
    .sync_out(sync_out), .filt_out(filt_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
`ifdef SYNC_GLITCH_COUNT_EN
    , .glitch_clr(glitch_clr), .glitch_count(glitch_count)
`endif
  );

  sync_filter_signals #(
    .WIDTH(1), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(1'b0)
  ) dut6 (
    .clk(clk), .reset_n(reset_n), .async_in(async_in6),
    .sync_out(sync_out6), .filt_out(filt_out6),
    .rise_pulse(rise_pulse6), .fall_pulse(fall_pulse6)
`ifdef SYNC_GLITCH_COUNT_EN
    , .glitch_clr(glitch_clr6), .glitch_count(glitch_count6)
`endif
  );

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    async_in  = 4'hF;
    async_in6 = 1'b0;
`ifdef SYNC_GLITCH_COUNT_EN
    glitch_clr  = 1'b0;
    glitch_clr6 = 1'b0;
`endif
    tick(10);
    total++; if (sync_out !== 4'h0) $display("FAIL reset_sync actual=%h required=%h", sync_out, 4'h0); else pass_cnt++;
    total++; if (filt_out !== 4'h0) $display("FAIL reset_filt actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    total++; if ((rise_pulse | fall_pulse) !== 4'h0) $display("FAIL reset_pulses actual=%h/%h required=0/0", rise_pulse, fall_pulse); else pass_cnt++;
`ifdef SYNC_GLITCH_COUNT_EN
    total++; if (glitch_count !== 16'h0) $display("FAIL reset_gcount actual=%h required=%h", glitch_count, 16'h0); else pass_cnt++;
`endif
    reset_n = 1'b1;
    tick(4);
    total++; if (filt_out !== 4'h0) $display("FAIL rel_filt_e4 actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    tick();
    total++; if (filt_out !== 4'hF) $display("FAIL rel_filt_e5 actual=%h required=%h", filt_out, 4'hF); else pass_cnt++;
    total++; if (rise_pulse !== 4'hF) $display("FAIL rel_rise_e5 actual=%h required=%h", rise_pulse, 4'hF); else pass_cnt++;
    tick();
    total++; if (rise_pulse !== 4'h0) $display("FAIL rel_rise_e6 actual=%h required=%h", rise_pulse, 4'h0); else pass_cnt++;
  endtask

  task automatic test_clean_step();
    async_in = 4'h0;
    tick(8);
    total++; if (filt_out !== 4'h0) $display("FAIL step_pre_filt actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    async_in = 4'h1;
    tick();
    total++; if (sync_out !== 4'h0) $display("FAIL step_sync_e1 actual=%h required=%h", sync_out, 4'h0); else pass_cnt++;
    tick();
    total++; if (sync_out !== 4'h1) $display("FAIL step_sync_e2 actual=%h required=%h", sync_out, 4'h1); else pass_cnt++;
    tick(2);
    total++; if (filt_out !== 4'h0) $display("FAIL step_filt_e4 actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    tick();
    total++; if (filt_out !== 4'h1) $display("FAIL step_filt_e5 actual=%h required=%h", filt_out, 4'h1); else pass_cnt++;
    total++; if (rise_pulse !== 4'h1 || fall_pulse !== 4'h0) $display("FAIL step_pulse_e5 actual=%h/%h required=1/0", rise_pulse, fall_pulse); else pass_cnt++;
    tick();
    total++; if (rise_pulse !== 4'h0) $display("FAIL step_rise_e6 actual=%h required=%h", rise_pulse, 4'h0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic bad;
`ifdef SYNC_GLITCH_COUNT_EN
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    total++; if (glitch_count !== 16'h0) $display("FAIL glitch_pre_count actual=%h required=%h", glitch_count, 16'h0); else pass_cnt++;
`endif
    async_in = 4'h3;
    tick(2);
    async_in = 4'h1;
    total++; if (sync_out !== 4'h3) $display("FAIL glitch_sync_e2 actual=%h required=%h", sync_out, 4'h3); else pass_cnt++;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (filt_out !== 4'h1 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL glitch_leak actual=%b required=%b", bad, 1'b0); else pass_cnt++;
`ifdef SYNC_GLITCH_COUNT_EN
    total++; if (glitch_count !== 16'h1) $display("FAIL glitch_count actual=%h required=%h", glitch_count, 16'h1); else pass_cnt++;
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    total++; if (glitch_count !== 16'h0) $display("FAIL glitch_clr actual=%h required=%h", glitch_count, 16'h0); else pass_cnt++;
`endif
  endtask

  task automatic test_simultaneous();
    async_in = 4'b1001;
    tick(8);
    total++; if (filt_out !== 4'b1001) $display("FAIL simul_pre_filt actual=%h required=%h", filt_out, 4'b1001); else pass_cnt++;
    async_in = 4'b0101;
    tick(4);
    total++; if ((rise_pulse | fall_pulse) !== 4'h0) $display("FAIL simul_early actual=%h/%h required=0/0", rise_pulse, fall_pulse); else pass_cnt++;
    tick();
    total++; if (rise_pulse !== 4'b0100) $display("FAIL simul_rise actual=%h required=%h", rise_pulse, 4'b0100); else pass_cnt++;
    total++; if (fall_pulse !== 4'b1000) $display("FAIL simul_fall actual=%h required=%h", fall_pulse, 4'b1000); else pass_cnt++;
    total++; if (filt_out !== 4'b0101) $display("FAIL simul_filt actual=%h required=%h", filt_out, 4'b0101); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    async_in = 4'b0100;
    tick(8);
    async_in = 4'b0101;
    tick(4);
    total++; if (filt_out !== 4'b0100) $display("FAIL mid_pre_filt actual=%h required=%h", filt_out, 4'b0100); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total++; if (filt_out !== 4'h0) $display("FAIL mid_rst_filt actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    total++; if ((rise_pulse | fall_pulse) !== 4'h0) $display("FAIL mid_rst_pulse actual=%h/%h required=0/0", rise_pulse, fall_pulse); else pass_cnt++;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    total++; if (filt_out !== 4'h0) $display("FAIL mid_filt_e4 actual=%h required=%h", filt_out, 4'h0); else pass_cnt++;
    tick();
    total++; if (filt_out !== 4'b0101) $display("FAIL mid_filt_e5 actual=%h required=%h", filt_out, 4'b0101); else pass_cnt++;
    total++; if (rise_pulse !== 4'b0101) $display("FAIL mid_rise_e5 actual=%h required=%h", rise_pulse, 4'b0101); else pass_cnt++;
  endtask

  task automatic test_param_corner();
    async_in6 = 1'b1;
    tick(3);
    total++; if (filt_out6 !== 1'b0) $display("FAIL c6_step_e3 actual=%b required=%b", filt_out6, 1'b0); else pass_cnt++;
    tick();
    total++; if (filt_out6 !== 1'b1 || rise_pulse6 !== 1'b1) $display("FAIL c6_step_e4 actual=%b/%b required=1/1", filt_out6, rise_pulse6); else pass_cnt++;
    async_in6 = 1'b0;
    tick(6);
    total++; if (filt_out6 !== 1'b0) $display("FAIL c6_back_low actual=%b required=%b", filt_out6, 1'b0); else pass_cnt++;
    async_in6 = 1'b1;
    tick();
    async_in6 = 1'b0;
    tick(2);
    total++; if (filt_out6 !== 1'b0) $display("FAIL c6_pulse_e3 actual=%b required=%b", filt_out6, 1'b0); else pass_cnt++;
    tick();
    total++; if (filt_out6 !== 1'b1 || rise_pulse6 !== 1'b1 || fall_pulse6 !== 1'b0) $display("FAIL c6_pulse_e4 actual=%b/%b/%b required=1/1/0", filt_out6, rise_pulse6, fall_pulse6); else pass_cnt++;
    tick();
    total++; if (filt_out6 !== 1'b0 || rise_pulse6 !== 1'b0 || fall_pulse6 !== 1'b1) $display("FAIL c6_pulse_e5 actual=%b/%b/%b required=0/0/1", filt_out6, rise_pulse6, fall_pulse6); else pass_cnt++;
    tick();
    total++; if (fall_pulse6 !== 1'b0) $display("FAIL c6_pulse_e6 actual=%b required=%b", fall_pulse6, 1'b0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_param_corner();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_filter_signals.md
Name: sync_filter_signals

Overview:
Parametrised multi-channel successor to the existing 2-flop input synchronizer used on the RGB/csync video inputs. Each asynchronous input bit passes through a configurable-depth synchronizer, then a per-channel glitch filter (persistence counter), then an edge detector. Outputs feed the video capture and sync-separation logic in the 81 MHz domain. The block provides both the raw synchronized level and a debounced level with rise/fall strobes.

Parameters:
WIDTH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchronizer flops per channel (>=2)
FILTER_CYCLES, 3, consecutive clocks a new synchronized level must persist before acceptance (>=1)
RESET_VALUE, 0, WIDTH-bit reset level for the sync chains and filt_out

Ports:
clk  input  1  system clock (81 MHz)
reset_n  input  1  asynchronous active-low reset
async_in  input  WIDTH  asynchronous input bits (e.g. {R,G,B,csync})
sync_out  output  WIDTH  raw synchronized level (last sync stage)
filt_out  output  WIDTH  filtered/debounced level
rise_pulse  output  WIDTH  1-cycle strobe when filt_out goes 0->1
fall_pulse  output  WIDTH  1-cycle strobe when filt_out goes 1->0

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n). While reset_n=0: every sync stage and filt_out equal RESET_VALUE per bit; all filter counters = 0; rise_pulse = fall_pulse = 0. Release is sampled at the next clk edge; no output changes on the release itself.
- Sync chain: per channel, shift register of SYNC_STAGES flops; sync_out = last stage. Input change is visible on sync_out after SYNC_STAGES edges.
- Filter, per channel, counter width $clog2(FILTER_CYCLES+1), evaluated each edge:
  - sync_out == filt_out: counter <= 0.
  - sync_out != filt_out and counter == FILTER_CYCLES-1: filt_out <= sync_out, counter <= 0, assert the matching pulse.
  - sync_out != filt_out otherwise: counter <= counter+1.
- Latency: a clean step on async_in reaches filt_out after SYNC_STAGES+FILTER_CYCLES edges. FILTER_CYCLES=1 gives one extra edge only.
- Glitch rejection: a pulse on sync_out shorter than FILTER_CYCLES clocks never reaches filt_out. The counter clears on the cycle sync_out returns to filt_out.
- Pulses: registered. They are high in exactly the cycle filt_out shows its new value and are low otherwise. rise_pulse and fall_pulse are never both high on the same channel.
- Channels are fully independent. Simultaneous transitions on multiple channels produce pulses in the same cycle.
- Reset asserted mid-filter aborts the count. After release, the full SYNC_STAGES+FILTER_CYCLES latency applies again.

Optional Feature:
SYNC_GLITCH_COUNT_EN
- Defined: adds input glitch_clr (1 bit) and output glitch_count (16 bits).
  - A reject event is any cycle in which at least one channel has counter != 0 and sync_out == filt_out.
  - glitch_count increments by 1 per cycle containing one or more reject events, and saturates at 16'hFFFF.
  - glitch_clr is synchronous, active-high, and has priority over increment.
  - glitch_count resets to 0 on reset_n.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset hold: WIDTH=4, RESET_VALUE=0, reset_n=0, async_in=4'hF for 10 clks -> sync_out=filt_out=0, no pulses. Release, then after edge 5 -> filt_out=4'hF, rise_pulse=4'hF for 1 cycle.
2. Clean step: SYNC_STAGES=2, FILTER_CYCLES=3. async_in[0] 0->1 before edge 0 -> sync_out[0]=1 after edge 2; filt_out[0]=1 and rise_pulse[0]=1 after edge 5; pulse low after edge 6.
3. Glitch: async_in[1] high for exactly 2 clks -> sync_out[1] pulses 2 cycles, filt_out[1] stays 0, no pulse. With SYNC_GLITCH_COUNT_EN, glitch_count 0->1; glitch_clr=1 for one edge -> 0.
4. Simultaneous: filt_out[3]=1, filt_out[2]=0; async_in[3:2] 2'b10->2'b01 in the same cycle -> rise_pulse[2] and fall_pulse[3] high in the same cycle, 5 edges later.
5. Reset mid-operation: pull reset_n low while channel 0's counter=2 -> filt_out[0] stays/returns to 0 immediately with no pulse. After release with async_in[0]=1 held, filt_out[0]=1 occurs only 5 edges later.
6. Parameter corner: SYNC_STAGES=3, FILTER_CYCLES=1 -> step appears on filt_out after edge 4. A 1-clk-wide input pulse (longer than 1 sync sample) propagates as a 1-cycle filt_out pulse with rise then fall strobes.
